cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Sequencing controller for the 4-entry fully-associative data cache between the CPU load/store port and main memory. Owns entry tags, valid bits, data and 2-bit LRU counters. Performs lookup, serves hits, fetches on read miss with a req/ack memory handshake, and writes through on stores. One request in flight at a time.

Parameters:
d_width, 8, data bus width
a_width, 8, address width
mem_timeout, 255, maximum cycles waiting on mem_ack before error abort (8-bit counter)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
cpu_req  input  1  request strobe, sampled only when cpu_ready=1
cpu_we  input  1  1=store, 0=load
cpu_addr  input  a_width  request address
cpu_wdata  input  d_width  store data
cpu_ready  output  1  controller idle, can accept a request
cpu_ack  output  1  one-cycle completion pulse
cpu_rdata  output  d_width  load data, valid while cpu_ack=1
cpu_hit  output  1  hit/miss status of completed request, valid with cpu_ack
cpu_err  output  1  one-cycle pulse with cpu_ack when a memory timeout occurred
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write enable, stable while mem_req=1
mem_addr  output  a_width  memory address, stable while mem_req=1
mem_wdata  output  d_width  memory write data
mem_ack  input  1  memory completion (one cycle)
mem_rdata  input  d_width  memory read data, valid with mem_ack

Behaviour:
- Reset (async, active-high): state IDLE; all valid=0; all counters=0; cpu_ready=1; cpu_ack, cpu_hit, cpu_err, mem_req, mem_we=0; cpu_rdata, mem_addr, mem_wdata=0. Reset mid-operation aborts immediately; mem_req drops in same cycle; no ack issued.
- States: IDLE, LOOKUP, FETCH, WRITE, RESP.
- IDLE: cpu_ready=1. cpu_req=1 registers we/addr/wdata, goes to LOOKUP. cpu_ready=0 in all other states.
- LOOKUP (1 cycle): hit = any valid entry whose tag equals the registered addr; lowest index wins if duplicates.
  - load hit -> RESP, cpu_rdata=entry data, cpu_hit=1. Total latency req->ack = 2 cycles.
  - load miss -> select victim: lowest-index invalid entry, else lowest-index entry with counter 0. Go to FETCH.
  - store (hit or miss) -> WRITE; on hit, entry data updated with wdata in this cycle. Store miss does not allocate.
- FETCH: mem_req=1, mem_we=0, mem_addr=addr. On mem_ack: victim tag=addr, data=mem_rdata, valid=1, LRU update; cpu_rdata=mem_rdata, cpu_hit=0 -> RESP.
- WRITE: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata. On mem_ack -> RESP, cpu_hit=hit.
- RESP: cpu_ack=1 for exactly one cycle, then IDLE. cpu_rdata and cpu_hit hold until the next ack.
- Timeout: wait counter cleared on entering FETCH/WRITE, increments each cycle without mem_ack; when it equals mem_timeout, drop mem_req, go to RESP with cpu_err=1, cpu_hit=0, no cache state change. mem_ack in the same cycle as the limit takes priority (normal completion).
- LRU update on access to entry i (load hit, store hit, fill): every other valid entry j with cnt[j] > cnt[i] decrements; cnt[i]=3. On fill of an invalid entry, treat old cnt[i] as 0 for the comparison. Counters saturate: never below 0, never above 3. Counters stay a permutation of distinct values among valid entries. Store miss and timeout leave counters unchanged.
- mem_addr/mem_we/mem_wdata change only when mem_req is low or on entry to FETCH/WRITE.
- cpu_req while cpu_ready=0 is ignored (not queued).

Test Plan:
- Reset then load 0x10, memory acks after 3 cycles with 0xA5 -> mem_req high 3 cycles, mem_we=0, cpu_ack with rdata=0xA5, hit=0; entry0 valid, cnt0=3.
- Repeat load 0x10 -> ack 2 cycles after req, rdata=0xA5, hit=1, mem_req never asserted.
- Loads 0x01,0x02,0x03,0x04, then 0x01, then 0x05 -> 0x05 replaces the 0x02 entry (cnt 0); reload 0x01 hits, reload 0x02 misses.
- Store 0x03 data 0x5A after fill -> mem write addr 0x03 data 0x5A, hit=1; next load 0x03 hits with 0x5A. Store 0x77 miss -> written to memory, not allocated (later load 0x77 misses).
- Load miss, mem_ack never arrives, mem_timeout=4 -> mem_req drops after 4 cycles, cpu_ack+cpu_err pulse, no entry valid.
- Assert rst during FETCH -> mem_req=0 and cpu_ready=1 immediately, no cpu_ack, prior hits now miss.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - CPU load/store port and memory port bundle for cache_ctrl
interface cache_ctrl_if #(
  parameter int d_width = 8,
  parameter int a_width = 8
);
  logic               cpu_req;
  logic               cpu_we;
  logic [a_width-1:0] cpu_addr;
  logic [d_width-1:0] cpu_wdata;
  logic               cpu_ready;
  logic               cpu_ack;
  logic [d_width-1:0] cpu_rdata;
  logic               cpu_hit;
  logic               cpu_err;
  logic               mem_req;
  logic               mem_we;
  logic [a_width-1:0] mem_addr;
  logic [d_width-1:0] mem_wdata;
  logic               mem_ack;
  logic [d_width-1:0] mem_rdata;

  // master: the CPU/memory environment; slave: the cache controller
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_ack, cpu_rdata, cpu_hit, cpu_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_ack, cpu_rdata, cpu_hit, cpu_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 4-entry fully-associative write-through cache sequencer with LRU
module cache_ctrl #(
  parameter int d_width     = 8,
  parameter int a_width     = 8,
  parameter int mem_timeout = 255
) (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, FETCH, WRITE, RESP} state_t;

  localparam logic [7:0] wait_lim = 8'(mem_timeout - 1);

  state_t             state, state_n;
  logic               req_we;
  logic [a_width-1:0] req_addr;
  logic [d_width-1:0] req_wdata;
  logic [3:0]         valid;
  logic [a_width-1:0] tag   [4];
  logic [d_width-1:0] data  [4];
  logic [1:0]         cnt   [4];
  logic [1:0]         victim_r;
  logic               hit_q;
  logic [7:0]         wait_cnt;
  logic [d_width-1:0] rdata_r;
  logic               hit_r;
  logic               err_r;
  logic               mem_we_r;
  logic [a_width-1:0] mem_addr_r;
  logic [d_width-1:0] mem_wdata_r;

  logic               hit;
  logic [1:0]         hit_idx;
  logic [1:0]         victim;
  logic               acc_en;
  logic [1:0]         acc_idx;
  logic [1:0]         acc_old;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    victim  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid[i] && tag[i] == req_addr) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (cnt[i] == 2'd0) victim = 2'(i);
    end
    for (int i = 3; i >= 0; i--) begin
      if (!valid[i]) victim = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    acc_en  = 1'b0;
    acc_idx = hit_idx;
    case (state)
      IDLE:   if (bus.cpu_req) state_n = LOOKUP;
      LOOKUP: begin
        acc_en = hit;
        if (req_we)   state_n = WRITE;
        else if (hit) state_n = RESP;
        else          state_n = FETCH;
      end
      FETCH: begin
        acc_idx = victim_r;
        if (bus.mem_ack) begin
          acc_en  = 1'b1;
          state_n = RESP;
        end else if (wait_cnt == wait_lim) begin
          state_n = RESP;
        end
      end
      WRITE:  if (bus.mem_ack || wait_cnt == wait_lim) state_n = RESP;
      RESP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A never-filled entry competes as if its counter were 0.
  assign acc_old = valid[acc_idx] ? cnt[acc_idx] : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      valid       <= '0;
      victim_r    <= 2'd0;
      hit_q       <= 1'b0;
      wait_cnt    <= 8'd0;
      rdata_r     <= '0;
      hit_r       <= 1'b0;
      err_r       <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      for (int i = 0; i < 4; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
        cnt[i]  <= 2'd0;
      end
    end else begin
      case (state)
        IDLE: if (bus.cpu_req) begin
          req_we    <= bus.cpu_we;
          req_addr  <= bus.cpu_addr;
          req_wdata <= bus.cpu_wdata;
        end
        LOOKUP: begin
          wait_cnt <= 8'd0;
          victim_r <= victim;
          hit_q    <= hit;
          if (req_we || !hit) begin
            mem_we_r    <= req_we;
            mem_addr_r  <= req_addr;
            mem_wdata_r <= req_wdata;
          end
          if (req_we && hit) data[hit_idx] <= req_wdata;
          if (!req_we && hit) begin
            rdata_r <= data[hit_idx];
            hit_r   <= 1'b1;
            err_r   <= 1'b0;
          end
        end
        FETCH, WRITE: begin
          if (bus.mem_ack) begin
            err_r <= 1'b0;
            if (state == FETCH) begin
              tag[victim_r]   <= req_addr;
              data[victim_r]  <= bus.mem_rdata;
              valid[victim_r] <= 1'b1;
              rdata_r         <= bus.mem_rdata;
              hit_r           <= 1'b0;
            end else begin
              hit_r <= hit_q;
            end
          end else if (wait_cnt == wait_lim) begin
            hit_r <= 1'b0;
            err_r <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
      if (acc_en) begin
        for (int j = 0; j < 4; j++) begin
          if (2'(j) != acc_idx && valid[j] && cnt[j] > acc_old) cnt[j] <= cnt[j] - 2'd1;
        end
        cnt[acc_idx] <= 2'd3;
      end
    end
  end

  assign bus.cpu_ready = (state == IDLE);
  assign bus.cpu_ack   = (state == RESP);
  assign bus.cpu_err   = (state == RESP) && err_r;
  assign bus.cpu_rdata = rdata_r;
  assign bus.cpu_hit   = hit_r;
  assign bus.mem_req   = (state == FETCH) || (state == WRITE);
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - randomized bench for cache_ctrl against a recency-list cache model
module tb_cache_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  cache_ctrl_if #(.d_width(8), .a_width(8)) bus ();

  cache_ctrl #(.d_width(8), .a_width(8), .mem_timeout(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  bit         m_valid [4];
  logic [7:0] m_tag   [4];
  logic [7:0] m_data  [4];
  int         lru_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    lru_q.delete();
  endtask

  task automatic touch(input int idx);
    for (int k = lru_q.size() - 1; k >= 0; k--) if (lru_q[k] == idx) lru_q.delete(k);
    lru_q.push_back(idx);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(bus.cpu_ready), 32'd1);
    check("rst_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_hit", 32'(bus.cpu_hit), 32'd0);
    check("rst_err", 32'(bus.cpu_err), 32'd0);
    check("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One CPU transaction; dly = mem_req cycle in which mem_ack is returned, drop = never ack.
  task automatic do_op(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                       input int dly, input bit drop);
    int hit_i, v, e_mem, cyc, req_cycles;
    bit e_hit, e_err, done;
    logic [7:0] e_rd;
    hit_i = -1;
    e_err = drop;
    e_rd  = 8'h00;
    for (int i = 3; i >= 0; i--) if (m_valid[i] && m_tag[i] == addr) hit_i = i;
    if (!we && hit_i >= 0) begin
      e_hit = 1'b1;
      e_rd  = m_data[hit_i];
      e_mem = 0;
      e_err = 1'b0;
      touch(hit_i);
    end else if (!we) begin
      e_hit = 1'b0;
      e_mem = drop ? TMO : dly;
      if (!drop) begin
        v = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) v = i;
        if (v < 0) v = lru_q[0];
        m_valid[v] = 1'b1;
        m_tag[v]   = addr;
        m_data[v]  = mem[addr];
        e_rd       = mem[addr];
        touch(v);
      end
    end else begin
      e_mem = drop ? TMO : dly;
      e_hit = !drop && (hit_i >= 0);
      if (hit_i >= 0) begin
        m_data[hit_i] = wdata;
        touch(hit_i);
      end
    end

    @(negedge clk);
    check("ready_before", 32'(bus.cpu_ready), 32'd1);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    cyc = 1;
    req_cycles = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      if (bus.cpu_ack) begin
        done = 1'b1;
      end else begin
        if (bus.mem_req) begin
          req_cycles++;
          check("mem_we", 32'(bus.mem_we), 32'(we));
          check("mem_addr", 32'(bus.mem_addr), 32'(addr));
          if (we) check("mem_wdata", 32'(bus.mem_wdata), 32'(wdata));
          if (!drop && req_cycles == dly) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr];
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          end
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        cyc++;
      end
    end
    check("ack_seen", 32'(done), 32'd1);
    check("latency", 32'(cyc), 32'(e_mem + 2));
    check("mem_cycles", 32'(req_cycles), 32'(e_mem));
    check("hit", 32'(bus.cpu_hit), 32'(e_hit));
    check("err", 32'(bus.cpu_err), 32'(e_err));
    if (!we && !drop) check("rdata", 32'(bus.cpu_rdata), 32'(e_rd));
    @(negedge clk);
    check("ack_pulse", 32'(bus.cpu_ack), 32'd0);
    check("err_pulse", 32'(bus.cpu_err), 32'd0);
    check("ready_after", 32'(bus.cpu_ready), 32'd1);
  endtask

  task automatic reset_mid_fetch(input logic [7:0] addr);
    int n;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = addr;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("fetch_started", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_ready", 32'(bus.cpu_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_no_ack", 32'(bus.cpu_ack), 32'd0);
    end
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'h00;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5;
    model_clear();
    #2 check_reset_outputs();
    do_reset();

    do_op(1'b0, 8'h10, 8'h00, 3, 1'b0);
    do_op(1'b0, 8'h10, 8'h00, 1, 1'b0);

    do_reset();
    for (int a = 1; a <= 4; a++) do_op(1'b0, 8'(a), 8'h00, $urandom_range(1, 3), 1'b0);
    do_op(1'b0, 8'h01, 8'h00, 1, 1'b0);
    do_op(1'b0, 8'h05, 8'h00, 2, 1'b0);
    do_op(1'b0, 8'h01, 8'h00, 1, 1'b0);
    do_op(1'b0, 8'h02, 8'h00, 1, 1'b0);

    do_op(1'b1, 8'h03, 8'h5A, 2, 1'b0);
    check("mem_written", 32'(mem[8'h03]), 32'h5A);
    do_op(1'b0, 8'h03, 8'h00, 1, 1'b0);
    do_op(1'b1, 8'h77, 8'h3C, 1, 1'b0);
    do_op(1'b0, 8'h77, 8'h00, 2, 1'b0);

    do_reset();
    do_op(1'b0, 8'h20, 8'h00, 1, 1'b1);
    do_op(1'b0, 8'h20, 8'h00, 1, 1'b0);

    reset_mid_fetch(8'h40);
    do_op(1'b0, 8'h20, 8'h00, 2, 1'b0);

    for (int n = 0; n < 200; n++) begin
      bit we;
      we = ($urandom_range(0, 3) == 0);
      do_op(we, 8'($urandom_range(0, 7)), 8'($urandom), $urandom_range(1, 3),
            !we && ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
